uxn_stack_unit: RTL

- Byte-wide LIFO stack responder serving push/pop/peek/clear requests from the uxn core's execute/update stages.
- One instance backs the working stack and one backs the return stack.
- Handles byte and short (16-bit, big-endian) accesses, with overflow/underflow detection and a valid/ready request/response handshake.
- Multi-cycle: one byte-array access per cycle.

---
 rtl/uxn_stack_unit.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/uxn_stack_unit.sv
`default_nettype none
// ============================================================================
// Module   : uxn_stack_unit
// Purpose  : Byte-wide LIFO stack (push/pop/peek/clear, byte or big-endian short)
// Revision : 1.0
// ============================================================================
module uxn_stack_unit #(
  parameter int DEPTH = 256,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic          req_short,
  input  logic [15:0]   req_wdata,
  input  logic [PW-1:0] req_offset,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [15:0]   rsp_rdata,
  output logic          rsp_err,
  output logic [PW:0]   depth
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER_HI = 2'd1,
    XFER_LO = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic [1:0] OP_PUSH  = 2'b00;
  localparam logic [1:0] OP_POP   = 2'b01;
  localparam logic [1:0] OP_PEEK  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  state_t        state_q, state_d;
  logic [PW:0]   depth_q, depth_d;
  logic [1:0]    op_q, op_d;
  logic          short_q, short_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [PW-1:0] offset_q, offset_d;
  logic [15:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [7:0]    mem [DEPTH];

  logic [PW+1:0] d_ext, n_ext, off_ext;
  logic          req_err;
  logic [PW-1:0] ptr, addr_hi, addr_lo, mem_addr;
  logic          mem_we;
  logic [7:0]    mem_wbyte;
  logic [PW:0]   n_len;

  // Bounds are evaluated two bits wider than the pointer so D+n and off+n never wrap.
  always_comb begin
    d_ext   = {1'b0, depth_q};
    n_ext   = req_short ? (PW+2)'(2) : (PW+2)'(1);
    off_ext = (PW+2)'(req_offset);
    case (req_op)
      OP_PUSH: req_err = (d_ext + n_ext) > (PW+2)'(DEPTH);
      OP_POP:  req_err = n_ext > d_ext;
      OP_PEEK: req_err = (off_ext + n_ext) > d_ext;
      default: req_err = 1'b0;
    endcase
  end

  // POP is treated as PEEK at offset 0; depth only moves on the XFER_LO edge.
  always_comb begin
    ptr = depth_q[PW-1:0];
    if (op_q == OP_PUSH) begin
      addr_hi = ptr;
      addr_lo = ptr + PW'(short_q);
    end else begin
      addr_lo = ptr - PW'(1) - offset_q;
      addr_hi = addr_lo - PW'(1);
    end
    n_len = short_q ? (PW+1)'(2) : (PW+1)'(1);
  end

  always_comb begin
    state_d   = state_q;
    depth_d   = depth_q;
    op_d      = op_q;
    short_d   = short_q;
    wdata_d   = wdata_q;
    offset_d  = offset_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_addr  = addr_lo;
    mem_wbyte = wdata_q[7:0];
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d     = req_op;
          short_d  = req_short;
          wdata_d  = req_wdata;
          offset_d = (req_op == OP_PEEK) ? req_offset : '0;
          rdata_d  = '0;
          err_d    = req_err;
          if (req_err) begin
            state_d = RESP;
          end else if (req_op == OP_CLEAR) begin
            depth_d = '0;
            state_d = RESP;
          end else if (req_short) begin
            state_d = XFER_HI;
          end else begin
            state_d = XFER_LO;
          end
        end
      end
      XFER_HI: begin
        mem_addr  = addr_hi;
        mem_wbyte = wdata_q[15:8];
        mem_we    = (op_q == OP_PUSH);
        if (op_q != OP_PUSH) rdata_d[15:8] = mem[addr_hi];
        state_d   = XFER_LO;
      end
      XFER_LO: begin
        mem_we = (op_q == OP_PUSH);
        if (op_q != OP_PUSH) rdata_d[7:0] = mem[addr_lo];
        if (op_q == OP_PUSH)     depth_d = depth_q + n_len;
        else if (op_q == OP_POP) depth_d = depth_q - n_len;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      depth_q  <= '0;
      op_q     <= OP_PUSH;
      short_q  <= 1'b0;
      wdata_q  <= '0;
      offset_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      depth_q  <= depth_d;
      op_q     <= op_d;
      short_q  <= short_d;
      wdata_q  <= wdata_d;
      offset_q <= offset_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Array is never cleared; reset only suppresses an in-flight write.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[mem_addr] <= mem_wbyte;
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign depth     = depth_q;

endmodule
`default_nettype wire
